// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the pipelined ALU and its multiplier.
//   - Opcode encodings for the G_sel input.
//   - Bit positions of the Z/C/N/V flags inside ZCNVFlags.
//   - Encoding of the control FSM states.
// Optional feature macro: ALU_MUL_EN (MUL opcode and sequential multiplier).
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_OR   = 4'b1100;
    localparam logic [3:0] OP_AND  = 4'b1110;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_RUN  = 2'd1,
        ST_MUL_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add unsigned multiplier, one partial product per cycle.
// Ports:
//   clk, rst    clock (rising edge), asynchronous active-high reset
//   start_i     load a_i/b_i and begin a new multiplication
//   a_i, b_i    operands (sampled only while start_i is high)
//   done_o      high in the cycle whose clock edge performs the final step
//   product_o   2*WIDTH-bit product; valid with done_o and held afterwards
// Used by alu_pipe only when ALU_MUL_EN is defined.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int SHW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   mplier_q;
    logic [SHW-1:0]     count_q;
    logic               busy_q;

    // The product output is the accumulator after the current step, so the
    // final result is available in the same cycle as done_o. Once all
    // multiplier bits are shifted out, acc_d equals acc_q and stays stable.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    assign product_o = acc_d;
    assign done_o    = busy_q && (count_q == SHW'(WIDTH - 1));

    // One shift-add step per cycle while busy; start restarts from scratch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            acc_q    <= '0;
            mplier_q <= b_i;
            count_q  <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + SHW'(1);
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered, valid/ready handshaked ALU with Z/C/N/V flags.
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready   operation handshake (in_ready depends on out_ready)
//   G_sel, A, B           opcode and operands
//   out_valid / out_ready result handshake
//   G, ZCNVFlags          registered result and flags [3]=Z [2]=C [1]=N [0]=V
// Optional feature macro: ALU_MUL_EN adds the MUL opcode (0011) using the
// sequential multiplier alu_mul_seq; without it 0011 behaves as undefined.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       G_sel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] G,
    output logic [3:0]       ZCNVFlags
);

    localparam int SHW = $clog2(WIDTH);

    state_e             state_q;
    logic [WIDTH-1:0]   g_q;
    logic [3:0]         flags_q;
    logic               out_valid_q;

    logic [WIDTH-1:0]   result_d;
    logic [3:0]         flags_d;
    logic               carry_d;
    logic               ovf_d;
    logic               sub_op;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum_ext;
    logic [SHW-1:0]     shamt;
    logic               out_free;
    logic               accept;

    assign out_free  = !out_valid_q || out_ready;
    assign in_ready  = !rst && (state_q == ST_IDLE) && out_free;
    assign accept    = in_valid && in_ready;
    assign G         = g_q;
    assign ZCNVFlags = flags_q;
    assign out_valid = out_valid_q;
    assign shamt     = B[SHW-1:0];

    // Single-cycle datapath. SUB reuses the adder as A + ~B + 1 so its carry
    // out directly means "no borrow". Undefined opcodes fall to the default
    // branch, giving G = 0 and hence flags 4'b1000.
    always_comb begin
        sub_op   = (G_sel == OP_SUB);
        b_eff    = sub_op ? ~B : B;
        sum_ext  = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};
        result_d = '0;
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
        case (G_sel)
            OP_ADD, OP_SUB: begin
                result_d = sum_ext[WIDTH-1:0];
                carry_d  = sum_ext[WIDTH];
                ovf_d    = (A[WIDTH-1] == b_eff[WIDTH-1]) &&
                           (sum_ext[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLL:  result_d = A << shamt;
            OP_SRL:  result_d = A >> shamt;
            OP_SRA:  result_d = $unsigned($signed(A) >>> shamt);
            OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_XOR:  result_d = A ^ B;
            OP_OR:   result_d = A | B;
            OP_AND:  result_d = A & B;
            default: result_d = '0;
        endcase
        flags_d         = '0;
        flags_d[FLAG_Z] = (result_d == '0);
        flags_d[FLAG_C] = carry_d;
        flags_d[FLAG_N] = result_d[WIDTH-1];
        flags_d[FLAG_V] = ovf_d;
    end

`ifdef ALU_MUL_EN
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH-1:0]   mul_g;
    logic [3:0]         mul_flags;

    assign mul_start = accept && (G_sel == OP_MUL);

    alu_mul_seq #(
        .WIDTH     (WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .a_i       (A),
        .b_i       (B),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // MUL flags: carry signals that the upper product half was discarded.
    always_comb begin
        mul_g             = mul_product[WIDTH-1:0];
        mul_flags         = '0;
        mul_flags[FLAG_Z] = (mul_g == '0);
        mul_flags[FLAG_C] = |mul_product[2*WIDTH-1:WIDTH];
        mul_flags[FLAG_N] = mul_g[WIDTH-1];
    end
`endif

    // Control FSM and output register. A retiring result clears out_valid
    // unless something new loads in the same cycle, so a simultaneous
    // retire-and-accept keeps out_valid high with the new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            g_q         <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
`ifdef ALU_MUL_EN
                        if (G_sel == OP_MUL) begin
                            state_q <= ST_MUL_RUN;
                        end else begin
                            g_q         <= result_d;
                            flags_q     <= flags_d;
                            out_valid_q <= 1'b1;
                        end
`else
                        g_q         <= result_d;
                        flags_q     <= flags_d;
                        out_valid_q <= 1'b1;
`endif
                    end
                end
`ifdef ALU_MUL_EN
                ST_MUL_RUN: begin
                    if (mul_done) begin
                        if (out_free) begin
                            g_q         <= mul_g;
                            flags_q     <= mul_flags;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else begin
                            state_q <= ST_MUL_WAIT;
                        end
                    end
                end
                ST_MUL_WAIT: begin
                    if (out_free) begin
                        g_q         <= mul_g;
                        flags_q     <= mul_flags;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe (WIDTH = 32). Results are
// predicted from the arithmetic meaning of each opcode using 64-bit math.
// MUL directed tests are compiled in only when ALU_MUL_EN is defined.
module tb_alu_pipe;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    G_sel;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  G;
    logic [3:0]    ZCNVFlags;

    int checks = 0;
    int errors = 0;

    logic [3:0]  plainOps [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0110,
                                  4'b1000, 4'b1010, 4'b1011, 4'b1100, 4'b1110};
    logic [31:0] specials [5]  = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000,
                                  32'h7FFF_FFFF, 32'h1};

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .G_sel     (G_sel),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .G         (G),
        .ZCNVFlags (ZCNVFlags)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit isMul(input logic [3:0] op);
`ifdef ALU_MUL_EN
        return op == 4'b0011;
`else
        return (op == 4'b1111) && (op == 4'b0000);
`endif
    endfunction

    // Reference model: plain wide arithmetic on the opcode's meaning.
    function automatic void refModel(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] g,
                                     output logic [3:0] f);
        bit [63:0] wide;
        longint    sa, sb, sr;
        int        ia, ib;
        bit        c, v;
        ia = a;
        ib = b;
        sa = ia;
        sb = ib;
        c  = 1'b0;
        v  = 1'b0;
        g  = '0;
        case (op)
            4'b0000: begin
                wide = 64'(a) + 64'(b);
                g = wide[31:0];
                c = wide[32];
                sr = sa + sb;
                v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'b0001: begin
                wide = 64'(a) - 64'(b);
                g = wide[31:0];
                c = (a >= b);
                sr = sa - sb;
                v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'b0010: g = a << b[4:0];
            4'b1010: g = a >> b[4:0];
            4'b1011: begin
                sr = sa >>> b[4:0];
                g = sr[31:0];
            end
            4'b0100: g = (sa < sb) ? 32'd1 : 32'd0;
            4'b0110: g = (a < b) ? 32'd1 : 32'd0;
            4'b1000: g = a ^ b;
            4'b1100: g = a | b;
            4'b1110: g = a & b;
`ifdef ALU_MUL_EN
            4'b0011: begin
                wide = 64'(a) * 64'(b);
                g = wide[31:0];
                c = (wide[63:32] != 0);
            end
`endif
            default: g = '0;
        endcase
        f = {(g == 0), c, g[31], v};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one operation with the output free, then check latency and result.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        logic [31:0] expG;
        logic [3:0]  expF;
        int          waitCnt;
        int          lat;
        refModel(op, a, b, expG, expF);
        @(negedge clk);
        in_valid  = 1'b1;
        G_sel     = op;
        A         = a;
        B         = b;
        out_ready = 1'b1;
        waitCnt   = 0;
        while (!in_ready && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("accept_timeout", 32'(waitCnt < 200), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        G_sel    = 4'($urandom);
        A        = $urandom;
        B        = $urandom;
        lat      = 1;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        checkOutput($sformatf("latency op=%b", op), 32'(lat),
                    isMul(op) ? 32'(W + 1) : 32'd1);
        checkOutput($sformatf("G op=%b a=%h b=%h", op, a, b), G, expG);
        checkOutput($sformatf("flags op=%b a=%h b=%h", op, a, b),
                    32'(ZCNVFlags), 32'(expF));
    endtask

    initial begin : main
        logic [31:0] a1, b1, a2, b2, expG1, expG2, prevG;
        logic [3:0]  expF1, expF2, prevF, op;
        int          seenValid;

        // Reset state
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        G_sel = '0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_G", G, 32'd0);
        checkOutput("reset_flags", 32'(ZCNVFlags), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);

        // Directed boundary cases
        applyStimulus(4'b0000, 32'hFFFF_FFFF, 32'h1);
        applyStimulus(4'b0000, 32'h7FFF_FFFF, 32'h1);
        applyStimulus(4'b0001, 32'd3, 32'd5);
        applyStimulus(4'b0100, 32'hFFFF_FFFF, 32'h1);
        applyStimulus(4'b0110, 32'hFFFF_FFFF, 32'h1);
        applyStimulus(4'b1011, 32'h8000_0000, 32'h24);
        applyStimulus(4'b1010, 32'h8000_0000, 32'h24);
        applyStimulus(4'b0101, 32'h1234_5678, 32'h9ABC_DEF0);
        applyStimulus(4'b0011, 32'h0001_0000, 32'h0001_0000);

        // Randomised single operations, biased toward corner operands
        for (int i = 0; i < 40; i++) begin
            a1 = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            b1 = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            applyStimulus(4'($urandom_range(0, 15)), a1, b1);
        end

        // Back-to-back stream at full throughput
        prevG = '0;
        prevF = '0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checkOutput("stream_valid", 32'(out_valid), 32'd1);
                checkOutput("stream_G", G, prevG);
                checkOutput("stream_flags", 32'(ZCNVFlags), 32'(prevF));
            end
            if (i < 8) begin
                op = plainOps[$urandom_range(0, 9)];
                a1 = $urandom;
                b1 = $urandom;
                in_valid = 1'b1; G_sel = op; A = a1; B = b1; out_ready = 1'b1;
                refModel(op, a1, b1, prevG, prevF);
                checkOutput("stream_in_ready", 32'(in_ready), 32'd1);
            end else begin
                in_valid = 1'b0;
            end
        end

        // Output stall: out_ready low for 3 cycles with a second ADD waiting
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        refModel(4'b0000, a1, b1, expG1, expF1);
        refModel(4'b0000, a2, b2, expG2, expF2);
        @(negedge clk);
        in_valid = 1'b1; G_sel = 4'b0000; A = a1; B = b1; out_ready = 1'b0;
        @(negedge clk);
        checkOutput("stall_first_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_first_G", G, expG1);
        A = a2; B = b2;
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            checkOutput("stall_G_hold", G, expG1);
            checkOutput("stall_flags_hold", 32'(ZCNVFlags), 32'(expF1));
            if (i < 2) @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("stall_release_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("stall_second_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_second_G", G, expG2);
        checkOutput("stall_second_flags", 32'(ZCNVFlags), 32'(expF2));
        @(negedge clk);
        checkOutput("stall_drained", 32'(out_valid), 32'd0);

`ifdef ALU_MUL_EN
        // Reset in the middle of a multiplication drops it
        @(negedge clk);
        in_valid = 1'b1; G_sel = 4'b0011; A = 32'hFFFF; B = 32'h1234; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("mul_busy_in_ready", 32'(in_ready), 32'd0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("mul_reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("mul_reset_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seenValid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seenValid++;
        end
        checkOutput("mul_dropped", 32'(seenValid), 32'd0);
        applyStimulus(4'b0000, 32'd20, 32'd22);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
